// File: rtl/aes_pkg.sv
// Shared types, constants and helpers for the AES-256 key-expansion sequencer.
//   word_t     32-bit key-schedule word
//   NR/NK      round count and key-word count (fixed for AES-256)
//   RK_W/NW    round-key width and total number of schedule words
//   RCON_INIT  round constant used for the first RotWord step
//   xtime()    multiply by x in GF(2^8), used to advance rcon
//   rot_word() cyclic byte rotation of a word
//   state_t    sequencer FSM states
package aes_pkg;

    typedef logic [31:0] word_t;

    localparam int NR   = 14;
    localparam int NK   = 8;
    localparam int RK_W = 128;
    localparam int NW   = 4 * (NR + 1);  // 60 schedule words

    localparam logic [7:0] RCON_INIT = 8'h01;

    typedef enum logic [1:0] {
        IDLE,
        EXPAND,
        DONE
    } state_t;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic word_t rot_word(input word_t w);
        return {w[23:0], w[31:24]};
    endfunction

endpackage

// File: rtl/aes_subword.sv
// AES SubWord: applies the AES S-box to each of the four bytes of a word.
// Purely combinational; one instance is shared by every substitution step.
//   din   in   32  word to substitute
//   dout  out  32  substituted word
module aes_subword (
    input  logic [31:0] din,
    output logic [31:0] dout
);

    // S-box packed with entry 0x00 in the most significant byte.
    localparam logic [2047:0] SBOX_TBL = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX_TBL[(255 - int'(b)) * 8 +: 8];
    endfunction

    assign dout = {sbox(din[31:24]), sbox(din[23:16]), sbox(din[15:8]), sbox(din[7:0])};

endmodule

// File: rtl/aes256_key_sched_ctrl.sv
// Iterative AES-256 key-expansion sequencer. Accepts a 256-bit key by
// valid/ready, produces w[8..59] one word per cycle through one shared
// aes_subword, and stores the 15 round keys for indexed reads.
// Optional feature: define KEY_ZEROIZE_EN to add the zeroize input, which
// wipes all key material and returns the block to IDLE in one cycle.
//   clk        in   1    clock, rising edge
//   rst_n      in   1    synchronous active-low reset
//   key_valid  in   1    key offered
//   key_ready  out  1    key can be accepted (IDLE or DONE)
//   key        in   256  cipher key, key[255:224] is w[0]
//   busy       out  1    expansion in progress
//   done       out  1    all round keys valid
//   rd_en      in   1    round-key read request
//   rd_idx     in   4    round index 0..14
//   rd_data    out  128  registered round key, 0 on miss
//   rd_hit     out  1    requested round was already computed
//   zeroize    in   1    (KEY_ZEROIZE_EN only) wipe key material
module aes256_key_sched_ctrl
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         key_valid,
    output logic         key_ready,
    input  logic [255:0] key,
    output logic         busy,
    output logic         done,
    input  logic         rd_en,
    input  logic [3:0]   rd_idx,
    output logic [127:0] rd_data,
    output logic         rd_hit
`ifdef KEY_ZEROIZE_EN
    ,
    input  logic         zeroize
`endif
);

    state_t          state, state_next;
    logic [5:0]      idx;       // index of the next word to be written
    logic [7:0]      rcon;
    word_t           win [NK];  // win[0] = w[i-8] ... win[NK-1] = w[i-1]
    logic [RK_W-1:0] rk  [NR+1];

    logic  wipe, capture, step_rot, step_sub;
    word_t sub_in, sub_out, new_word;
    logic [1:0] wsel;
    logic [3:0] rd_sel;
    logic       rd_ok;

`ifdef KEY_ZEROIZE_EN
    assign wipe = zeroize;
`else
    assign wipe = 1'b0;
`endif

    assign key_ready = (state == IDLE) || (state == DONE);
    assign busy      = (state == EXPAND);
    assign done      = (state == DONE);
    assign capture   = key_valid && key_ready && !wipe;

    // Word-step selection: every 8th word rotates+substitutes, the 4th substitutes.
    assign step_rot = (idx[2:0] == 3'd0);
    assign step_sub = (idx[2:0] == 3'd4);
    assign sub_in   = step_rot ? rot_word(win[NK-1]) : win[NK-1];

    aes_subword u_subword (
        .din  (sub_in),
        .dout (sub_out)
    );

    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        new_word = win[0] ^ win[NK-1];
        if (step_rot) begin
            new_word = win[0] ^ sub_out ^ {rcon, 24'h0};
        end else if (step_sub) begin
            new_word = win[0] ^ sub_out;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (capture) state_next = EXPAND;
            EXPAND:  if (idx == 6'(NW - 1)) state_next = DONE;
            DONE:    if (capture) state_next = EXPAND;
            default: state_next = IDLE;
        endcase
        if (wipe) begin
            state_next = IDLE;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Word position inside its round key: w[4r] lands in the top 32 bits.
    assign wsel = ~idx[1:0];

    always_ff @(posedge clk) begin
        if (!rst_n || wipe) begin
            idx  <= '0;
            rcon <= '0;
            for (int i = 0; i < NK; i++) begin
                win[i] <= '0;
            end
            // NOTE: the round-key store is reset explicitly so no key material survives reset.
            for (int r = 0; r <= NR; r++) begin
                rk[r] <= '0;
            end
        end else if (capture) begin
            idx  <= 6'd8;
            rcon <= RCON_INIT;
            for (int i = 0; i < NK; i++) begin
                win[i] <= key[255 - 32*i -: 32];
            end
            rk[0] <= key[255:128];
            rk[1] <= key[127:0];
        end else if (state == EXPAND) begin
            idx <= idx + 6'd1;
            if (step_rot) begin
                rcon <= xtime(rcon);
            end
            for (int i = 0; i < NK - 1; i++) begin
                win[i] <= win[i+1];
            end
            win[NK-1] <= new_word;
            rk[idx[5:2]][wsel*32 +: 32] <= new_word;
        end
    end

    // A round is readable once its last word (4r+3) is below the write index;
    // the word being written this edge is deliberately not bypassed.
    assign rd_ok  = (rd_idx <= 4'(NR)) && ({rd_idx, 2'b11} < idx);
    assign rd_sel = (rd_idx > 4'(NR)) ? 4'd0 : rd_idx;

    always_ff @(posedge clk) begin
        if (!rst_n || wipe) begin
            rd_data <= '0;
            rd_hit  <= 1'b0;
        end else if (rd_en) begin
            rd_hit  <= rd_ok;
            rd_data <= rd_ok ? rk[rd_sel] : '0;
        end
    end

endmodule
